// File: rtl/guess_pkg.sv
// guess_pkg: shared types and widths for the guess_game controller.
//   game_state_t : round FSM states
//   NUM_W        : width of target / guess / generator number
//   TRY_W        : width of the accepted-guess counter
package guess_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} game_state_t;
    localparam int NUM_W = 7;
    localparam int TRY_W = 4;
endpackage

// File: rtl/guess_game_if.sv
// guess_game_if: player/generator bus of the guess_game controller.
//   master : drives number, start, guess_valid, guess; observes results
//   slave  : the controller side
interface guess_game_if;
    import guess_pkg::*;
    logic [NUM_W-1:0] number;
    logic             lfsr_enable;
    logic             start;
    logic             guess_valid;
    logic [NUM_W-1:0] guess;
    logic             too_high;
    logic             too_low;
    logic             correct;
    logic             lost;
    logic             guess_err;
    logic [TRY_W-1:0] tries;
    logic [NUM_W-1:0] target;
    logic             playing;
    modport master (
        output number, start, guess_valid, guess,
        input  lfsr_enable, too_high, too_low, correct, lost, guess_err, tries, target, playing
    );
    modport slave (
        input  number, start, guess_valid, guess,
        output lfsr_enable, too_high, too_low, correct, lost, guess_err, tries, target, playing
    );
endinterface

// File: rtl/guess_game.sv
// guess_game: latches a random target on start and scores up to MAX_TRIES guesses.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : guess_game_if.slave (generator number/enable, start, guesses, results)
module guess_game
    import guess_pkg::*;
#(
    parameter int MAX_TRIES = 7,
    parameter int MAX_NUM   = 99
) (
    input logic         clk,
    input logic         reset,
    guess_game_if.slave bus
);
    localparam logic [NUM_W-1:0] MAX_NUM_L   = NUM_W'(MAX_NUM);
    localparam logic [TRY_W-1:0] MAX_TRIES_L = TRY_W'(MAX_TRIES);

    game_state_t      state_q, state_d;
    logic [NUM_W-1:0] target_q, target_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             too_high_q, too_high_d;
    logic             too_low_q, too_low_d;
    logic             correct_q, correct_d;
    logic             lost_q, lost_d;
    logic             guess_err_q, guess_err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            tries_q     <= '0;
            too_high_q  <= 1'b0;
            too_low_q   <= 1'b0;
            correct_q   <= 1'b0;
            lost_q      <= 1'b0;
            guess_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            tries_q     <= tries_d;
            too_high_q  <= too_high_d;
            too_low_q   <= too_low_d;
            correct_q   <= correct_d;
            lost_q      <= lost_d;
            guess_err_q <= guess_err_d;
        end
    end

    // Outside PLAY only start matters; inside PLAY only guesses matter,
    // which also resolves simultaneous start/guess_valid.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        tries_d     = tries_q;
        too_high_d  = too_high_q;
        too_low_d   = too_low_q;
        correct_d   = correct_q;
        lost_d      = lost_q;
        guess_err_d = 1'b0;
        if (state_q != PLAY) begin
            if (bus.start) begin
                state_d    = PLAY;
                target_d   = bus.number;
                tries_d    = '0;
                too_high_d = 1'b0;
                too_low_d  = 1'b0;
                correct_d  = 1'b0;
                lost_d     = 1'b0;
            end
        end else if (bus.guess_valid) begin
            if (bus.guess > MAX_NUM_L) begin
                guess_err_d = 1'b1;
            end else begin
                tries_d    = tries_q + 1'b1;
                too_high_d = bus.guess > target_q;
                too_low_d  = bus.guess < target_q;
                if (bus.guess == target_q) begin
                    state_d   = WIN;
                    correct_d = 1'b1;
                end else if (tries_d == MAX_TRIES_L) begin
                    state_d    = LOSE;
                    lost_d     = 1'b1;
                    too_high_d = 1'b0;
                    too_low_d  = 1'b0;
                end
            end
        end
    end

    // Target is hidden until the round is decided.
    always_comb begin
        bus.lfsr_enable = state_q != PLAY;
        bus.playing     = state_q == PLAY;
        bus.target      = (state_q == WIN || state_q == LOSE) ? target_q : '0;
        bus.too_high    = too_high_q;
        bus.too_low     = too_low_q;
        bus.correct     = correct_q;
        bus.lost        = lost_q;
        bus.guess_err   = guess_err_q;
        bus.tries       = tries_q;
    end
endmodule
